// File: rtl/instruction_decode_stage_pkg.sv
// Shared opcode map, instruction field positions and decode class encoding.
// Pure declarations, no latency or flow control.
package instruction_decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JPC   = 6'h02;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_BRFL  = 6'h06;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OPCODE_LSB = 26;
  localparam int RS1_LSB    = 21;
  localparam int RS2_LSB    = 16;
  localparam int RD_R_LSB   = 11;
  localparam int RD_I_LSB   = 16;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_LSB    = 0;
  localparam int PC_OFF_LSB = 0;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_RTYPE,
    CLS_ALU_IMM_S,
    CLS_ALU_IMM_Z,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP_REG,
    CLS_JUMP_PC,
    CLS_ILLEGAL
  } inst_class_e;

  // An all-zero word is a NOP even though its opcode aliases R-type.
  function automatic inst_class_e classify(input logic [5:0] opcode, input logic all_zero);
    inst_class_e c;
    c = CLS_ILLEGAL;
    if (all_zero) begin
      c = CLS_NOP;
    end else begin
      case (opcode)
        OP_RTYPE:                 c = CLS_RTYPE;
        OP_ADDI, OP_SUBI:         c = CLS_ALU_IMM_S;
        OP_ANDI, OP_ORI:          c = CLS_ALU_IMM_Z;
        OP_LW:                    c = CLS_LOAD;
        OP_SW:                    c = CLS_STORE;
        OP_BEQZ, OP_BNEZ, OP_BRFL: c = CLS_BRANCH;
        OP_JR:                    c = CLS_JUMP_REG;
        OP_JPC:                   c = CLS_JUMP_PC;
        default:                  c = CLS_ILLEGAL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/instruction_decode_stage_field_decoder.sv
// Combinational instruction field decoder: produces the next decode entry and
// which source register fields the instruction actually reads. Zero latency.
module instruction_field_decoder
  import instruction_decode_stage_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int OPCODE_WIDTH      = 6,
  parameter int FUNCTION_WIDTH    = 6,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int IMMEDIATE_WIDTH   = 16,
  parameter int PC_OFFSET_WIDTH   = 26,
  parameter int DATA_WIDTH        = 32
) (
  input  logic [INSTRUCTION_WIDTH-1:0] i_instruction,
  output logic [OPCODE_WIDTH-1:0]      o_opcode,
  output logic [FUNCTION_WIDTH-1:0]    o_function,
  output logic [REG_ADDR_WIDTH-1:0]    o_rs1,
  output logic [REG_ADDR_WIDTH-1:0]    o_rs2,
  output logic [REG_ADDR_WIDTH-1:0]    o_rd,
  output logic                         o_reg_wr_en,
  output logic [DATA_WIDTH-1:0]        o_immediate,
  output logic                         o_imm_inst,
  output logic [PC_OFFSET_WIDTH-1:0]   o_pc_offset,
  output logic                         o_mem_rd_en,
  output logic                         o_mem_wr_en,
  output logic                         o_wb_sel,
  output logic                         o_branch,
  output logic                         o_jump,
  output logic                         o_jump_use_r,
  output logic                         o_illegal,
  output logic                         o_use_rs1,
  output logic                         o_use_rs2
);

  logic [OPCODE_WIDTH-1:0]    w_opcode;
  logic [FUNCTION_WIDTH-1:0]  w_func;
  logic [REG_ADDR_WIDTH-1:0]  w_rs1, w_rs2, w_rd_r, w_rd_i;
  logic [IMMEDIATE_WIDTH-1:0] w_imm;
  logic [DATA_WIDTH-1:0]      w_imm_sext, w_imm_zext;
  logic [PC_OFFSET_WIDTH-1:0] w_pc_off;
  inst_class_e                w_class;

  assign w_opcode   = i_instruction[OPCODE_LSB +: OPCODE_WIDTH];
  assign w_func     = i_instruction[FUNC_LSB +: FUNCTION_WIDTH];
  assign w_rs1      = i_instruction[RS1_LSB +: REG_ADDR_WIDTH];
  assign w_rs2      = i_instruction[RS2_LSB +: REG_ADDR_WIDTH];
  assign w_rd_r     = i_instruction[RD_R_LSB +: REG_ADDR_WIDTH];
  assign w_rd_i     = i_instruction[RD_I_LSB +: REG_ADDR_WIDTH];
  assign w_imm      = i_instruction[IMM_LSB +: IMMEDIATE_WIDTH];
  assign w_pc_off   = i_instruction[PC_OFF_LSB +: PC_OFFSET_WIDTH];
  assign w_imm_sext = {{(DATA_WIDTH-IMMEDIATE_WIDTH){w_imm[IMMEDIATE_WIDTH-1]}}, w_imm};
  assign w_imm_zext = {{(DATA_WIDTH-IMMEDIATE_WIDTH){1'b0}}, w_imm};
  assign w_class    = classify(w_opcode, i_instruction == '0);

  always_comb begin
    o_opcode     = w_opcode;
    o_function   = '0;
    o_rs1        = '0;
    o_rs2        = '0;
    o_rd         = '0;
    o_reg_wr_en  = 1'b0;
    o_immediate  = '0;
    o_imm_inst   = 1'b0;
    o_pc_offset  = '0;
    o_mem_rd_en  = 1'b0;
    o_mem_wr_en  = 1'b0;
    o_wb_sel     = 1'b0;
    o_branch     = 1'b0;
    o_jump       = 1'b0;
    o_jump_use_r = 1'b0;
    o_illegal    = 1'b0;
    o_use_rs1    = 1'b0;
    o_use_rs2    = 1'b0;
    case (w_class)
      CLS_RTYPE: begin
        o_rs1 = w_rs1;  o_rs2 = w_rs2;  o_rd = w_rd_r;  o_function = w_func;
        o_reg_wr_en = 1'b1;  o_use_rs1 = 1'b1;  o_use_rs2 = 1'b1;
      end
      CLS_ALU_IMM_S, CLS_ALU_IMM_Z, CLS_LOAD: begin
        o_rs1 = w_rs1;  o_rd = w_rd_i;  o_reg_wr_en = 1'b1;
        o_imm_inst = 1'b1;  o_use_rs1 = 1'b1;
        o_immediate = (w_class == CLS_ALU_IMM_Z) ? w_imm_zext : w_imm_sext;
        o_mem_rd_en = (w_class == CLS_LOAD);
        o_wb_sel    = (w_class == CLS_LOAD);
      end
      CLS_STORE: begin
        o_rs1 = w_rs1;  o_rs2 = w_rs2;  o_immediate = w_imm_sext;  o_imm_inst = 1'b1;
        o_mem_wr_en = 1'b1;  o_use_rs1 = 1'b1;  o_use_rs2 = 1'b1;
      end
      CLS_BRANCH: begin
        o_rs1 = w_rs1;  o_immediate = w_imm_sext;  o_branch = 1'b1;  o_use_rs1 = 1'b1;
      end
      CLS_JUMP_REG: begin
        o_rs1 = w_rs1;  o_jump = 1'b1;  o_jump_use_r = 1'b1;  o_use_rs1 = 1'b1;
      end
      CLS_JUMP_PC: begin
        o_pc_offset = w_pc_off;  o_jump = 1'b1;
      end
      CLS_ILLEGAL: o_illegal = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// One-entry registered decode stage, 1-cycle latency, valid/ready both sides;
// optional load-use bubble insertion under DECODE_HAZARD_DETECT_EN.
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int OPCODE_WIDTH      = 6,
  parameter int FUNCTION_WIDTH    = 6,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int IMMEDIATE_WIDTH   = 16,
  parameter int PC_OFFSET_WIDTH   = 26,
  parameter int PC_WIDTH          = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int STALL_CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic [PC_WIDTH-1:0]          pc_in,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OPCODE_WIDTH-1:0]      opcode_out,
  output logic [FUNCTION_WIDTH-1:0]    inst_function_out,
  output logic [REG_ADDR_WIDTH-1:0]    read_address1_out,
  output logic [REG_ADDR_WIDTH-1:0]    read_address2_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_out,
  output logic                         reg_wr_en_out,
  output logic [DATA_WIDTH-1:0]        immediate_out,
  output logic                         imm_inst_out,
  output logic [PC_OFFSET_WIDTH-1:0]   pc_offset_out,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic                         mem_data_rd_en_out,
  output logic                         mem_data_wr_en_out,
  output logic                         write_back_mux_sel_out,
  output logic                         branch_inst_out,
  output logic                         jump_inst_out,
  output logic                         jump_use_r_out,
  output logic                         illegal_inst_out,
  output logic                         stall_out,
  output logic [STALL_CNT_WIDTH-1:0]   stall_count_out
);

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]    opcode;
    logic [FUNCTION_WIDTH-1:0]  func;
    logic [REG_ADDR_WIDTH-1:0]  rs1;
    logic [REG_ADDR_WIDTH-1:0]  rs2;
    logic [REG_ADDR_WIDTH-1:0]  rd;
    logic                       reg_wr_en;
    logic [DATA_WIDTH-1:0]      imm;
    logic                       imm_inst;
    logic [PC_OFFSET_WIDTH-1:0] pc_off;
    logic [PC_WIDTH-1:0]        pc;
    logic                       mem_rd_en;
    logic                       mem_wr_en;
    logic                       wb_sel;
    logic                       branch;
    logic                       jump;
    logic                       jump_use_r;
    logic                       illegal;
  } entry_t;

  entry_t                     w_dec;
  entry_t                     r_entry;
  logic                       r_out_valid;
  logic [STALL_CNT_WIDTH-1:0] r_stall_count;
  logic                       w_use_rs1, w_use_rs2;
  logic                       w_hazard, w_stall, w_hold;

  assign w_dec.pc = pc_in;

  instruction_field_decoder #(
    .INSTRUCTION_WIDTH(INSTRUCTION_WIDTH), .OPCODE_WIDTH(OPCODE_WIDTH),
    .FUNCTION_WIDTH(FUNCTION_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .IMMEDIATE_WIDTH(IMMEDIATE_WIDTH), .PC_OFFSET_WIDTH(PC_OFFSET_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_field_decoder (
    .i_instruction(instruction_in),
    .o_opcode(w_dec.opcode),       .o_function(w_dec.func),
    .o_rs1(w_dec.rs1),             .o_rs2(w_dec.rs2),
    .o_rd(w_dec.rd),               .o_reg_wr_en(w_dec.reg_wr_en),
    .o_immediate(w_dec.imm),       .o_imm_inst(w_dec.imm_inst),
    .o_pc_offset(w_dec.pc_off),    .o_mem_rd_en(w_dec.mem_rd_en),
    .o_mem_wr_en(w_dec.mem_wr_en), .o_wb_sel(w_dec.wb_sel),
    .o_branch(w_dec.branch),       .o_jump(w_dec.jump),
    .o_jump_use_r(w_dec.jump_use_r), .o_illegal(w_dec.illegal),
    .o_use_rs1(w_use_rs1),         .o_use_rs2(w_use_rs2)
  );

`ifdef DECODE_HAZARD_DETECT_EN
  // Load-use: the held load's result is not yet available to a reader behind it.
  logic w_src_match;
  assign w_src_match = (w_use_rs1 && (w_dec.rs1 == r_entry.rd)) ||
                       (w_use_rs2 && (w_dec.rs2 == r_entry.rd));
  assign w_hazard = r_out_valid && r_entry.mem_rd_en && (r_entry.rd != '0) &&
                    in_valid && w_src_match;
`else
  logic w_unused_src;
  assign w_unused_src = w_use_rs1 ^ w_use_rs2;
  assign w_hazard     = 1'b0;
`endif

  assign w_hold    = r_out_valid && !out_ready;
  assign w_stall   = w_hazard && out_ready && !flush;
  assign in_ready  = !rst && (flush || ((!r_out_valid || out_ready) && !w_hazard));
  assign stall_out = w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_entry     <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_entry     <= '0;
    end else if (w_hold) begin
      r_out_valid <= r_out_valid;
    end else if (in_valid && !w_hazard) begin
      r_out_valid <= 1'b1;
      r_entry     <= w_dec;
    end else begin
      r_out_valid <= 1'b0;
      r_entry     <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != {STALL_CNT_WIDTH{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign out_valid              = r_out_valid;
  assign stall_count_out        = r_stall_count;
  assign opcode_out             = r_entry.opcode;
  assign inst_function_out      = r_entry.func;
  assign read_address1_out      = r_entry.rs1;
  assign read_address2_out      = r_entry.rs2;
  assign reg_wr_addr_out        = r_entry.rd;
  assign reg_wr_en_out          = r_entry.reg_wr_en;
  assign immediate_out          = r_entry.imm;
  assign imm_inst_out           = r_entry.imm_inst;
  assign pc_offset_out          = r_entry.pc_off;
  assign pc_out                 = r_entry.pc;
  assign mem_data_rd_en_out     = r_entry.mem_rd_en;
  assign mem_data_wr_en_out     = r_entry.mem_wr_en;
  assign write_back_mux_sel_out = r_entry.wb_sel;
  assign branch_inst_out        = r_entry.branch;
  assign jump_inst_out          = r_entry.jump;
  assign jump_use_r_out         = r_entry.jump_use_r;
  assign illegal_inst_out       = r_entry.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: reference decode model plus directed scenarios.
`timescale 1ns/1ps
module tb_instruction_decode_stage;

`ifdef DECODE_HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  localparam logic [31:0] I_ADDI  = 32'h2022FFFC;
  localparam logic [31:0] I_ORI   = 32'h3422FFFF;
  localparam logic [31:0] I_LW3   = {6'h23, 5'd1, 5'd3, 16'h0000};
  localparam logic [31:0] I_ADD   = {6'h00, 5'd3, 5'd5, 5'd4, 5'd0, 6'h20};
  localparam logic [31:0] I_LW0   = {6'h23, 5'd1, 5'd0, 16'h0008};
  localparam logic [31:0] I_ADD0  = {6'h00, 5'd0, 5'd6, 5'd7, 5'd0, 6'h20};
  localparam logic [31:0] I_SW    = {6'h2B, 5'd2, 5'd3, 16'hFFF0};
  localparam logic [31:0] I_SW3   = {6'h2B, 5'd9, 5'd3, 16'h0004};
  localparam logic [31:0] I_BEQZ  = {6'h04, 5'd4, 5'd0, 16'h8000};
  localparam logic [31:0] I_JR    = {6'h12, 5'd7, 21'h0};
  localparam logic [31:0] I_JPC   = {6'h02, 26'h3FFFFFF};
  localparam logic [31:0] I_ILL   = {6'h3F, 26'h0000123};

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] instruction_in, pc_in;
  logic [5:0]  opcode_out, inst_function_out;
  logic [4:0]  read_address1_out, read_address2_out, reg_wr_addr_out;
  logic        reg_wr_en_out, imm_inst_out, mem_data_rd_en_out, mem_data_wr_en_out;
  logic        write_back_mux_sel_out, branch_inst_out, jump_inst_out, jump_use_r_out;
  logic        illegal_inst_out, stall_out;
  logic [31:0] immediate_out, pc_out;
  logic [25:0] pc_offset_out;
  logic [15:0] stall_count_out;

  always #5 clk = ~clk;

  instruction_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in), .pc_in(pc_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode_out(opcode_out), .inst_function_out(inst_function_out),
    .read_address1_out(read_address1_out), .read_address2_out(read_address2_out),
    .reg_wr_addr_out(reg_wr_addr_out), .reg_wr_en_out(reg_wr_en_out),
    .immediate_out(immediate_out), .imm_inst_out(imm_inst_out),
    .pc_offset_out(pc_offset_out), .pc_out(pc_out),
    .mem_data_rd_en_out(mem_data_rd_en_out), .mem_data_wr_en_out(mem_data_wr_en_out),
    .write_back_mux_sel_out(write_back_mux_sel_out), .branch_inst_out(branch_inst_out),
    .jump_inst_out(jump_inst_out), .jump_use_r_out(jump_use_r_out),
    .illegal_inst_out(illegal_inst_out), .stall_out(stall_out),
    .stall_count_out(stall_count_out)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] imm;
    logic        immi;
    logic [25:0] off;
    logic [31:0] pc;
    logic        mrd, mwr, wb, br, jmp, jr, ill;
  } ent_t;

  ent_t dut_e;
  assign dut_e = {opcode_out, inst_function_out, read_address1_out, read_address2_out,
                  reg_wr_addr_out, reg_wr_en_out, immediate_out, imm_inst_out,
                  pc_offset_out, pc_out, mem_data_rd_en_out, mem_data_wr_en_out,
                  write_back_mux_sel_out, branch_inst_out, jump_inst_out,
                  jump_use_r_out, illegal_inst_out};

  int n_checks = 0;
  int n_fail = 0;
  int stalls_seen = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // What the stage must present for an instruction, from the ISA field rules.
  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    ent_t e;
    logic [5:0]  op;
    logic [31:0] sx, zx;
    op = ins[31:26];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0000, ins[15:0]};
    e = '0;
    e.pc = pc;
    e.op = op;
    if (ins != 32'h0) begin
      case (op)
        6'h00: begin e.rs1 = ins[25:21]; e.rs2 = ins[20:16]; e.rd = ins[15:11]; e.fn = ins[5:0]; e.wr = 1'b1; end
        6'h08, 6'h0A: begin e.rs1 = ins[25:21]; e.rd = ins[20:16]; e.imm = sx; e.immi = 1'b1; e.wr = 1'b1; end
        6'h0C, 6'h0D: begin e.rs1 = ins[25:21]; e.rd = ins[20:16]; e.imm = zx; e.immi = 1'b1; e.wr = 1'b1; end
        6'h23: begin e.rs1 = ins[25:21]; e.rd = ins[20:16]; e.imm = sx; e.immi = 1'b1; e.wr = 1'b1; e.mrd = 1'b1; e.wb = 1'b1; end
        6'h2B: begin e.rs1 = ins[25:21]; e.rs2 = ins[20:16]; e.imm = sx; e.immi = 1'b1; e.mwr = 1'b1; end
        6'h04, 6'h05, 6'h06: begin e.rs1 = ins[25:21]; e.imm = sx; e.br = 1'b1; end
        6'h12: begin e.rs1 = ins[25:21]; e.jmp = 1'b1; e.jr = 1'b1; end
        6'h02: begin e.off = ins[25:0]; e.jmp = 1'b1; end
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Bit 0: reads rs1 field, bit 1: reads rs2 field.
  function automatic logic [1:0] ref_uses(input logic [31:0] ins);
    if (ins == 32'h0) return 2'b00;
    case (ins[31:26])
      6'h00, 6'h2B: return 2'b11;
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h04, 6'h05, 6'h06, 6'h12: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  logic        m_vld = 1'b0;
  ent_t        m_e = '0;
  logic [15:0] m_cnt = 16'h0;

  function automatic logic m_hazard();
    logic [1:0] u;
    u = ref_uses(instruction_in);
    return HZ && m_vld && m_e.mrd && (m_e.rd != 5'd0) && in_valid &&
           ((u[0] && instruction_in[25:21] == m_e.rd) || (u[1] && instruction_in[20:16] == m_e.rd));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld = 1'b0; m_e = '0; m_cnt = 16'h0;
    end else begin
      logic hz;
      hz = m_hazard();
      if (hz && out_ready && !flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
      if (flush) begin
        m_vld = 1'b0; m_e = '0;
      end else if (m_vld && !out_ready) begin
        m_vld = m_vld;
      end else if (in_valid && !hz) begin
        m_vld = 1'b1; m_e = ref_decode(instruction_in, pc_in);
      end else begin
        m_vld = 1'b0; m_e = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", in_ready, flush || ((!m_vld || out_ready) && !m_hazard()));
      check("stall_out", stall_out, m_hazard() && out_ready && !flush);
      check("out_valid", out_valid, m_vld);
      check("stall_count", stall_count_out, m_cnt);
      if (m_vld) check("entry", dut_e, m_e);
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, output int iters);
    logic acc;
    acc = 1'b0;
    iters = 0;
    in_valid = 1'b1; instruction_in = ins; pc_in = pc;
    while (!acc && iters < 20) begin
      #1;
      acc = in_ready;
      if (stall_out) stalls_seen++;
      @(posedge clk); #2;
      iters++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", acc, 1);
  endtask

  logic [31:0] tbl [8];
  initial begin
    tbl[0] = I_LW3; tbl[1] = I_ADD; tbl[2] = I_SW3; tbl[3] = I_BEQZ;
    tbl[4] = I_ORI; tbl[5] = I_JPC; tbl[6] = I_LW0; tbl[7] = 32'h0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int it;
    int idx;
    rst = 1'b1; in_valid = 1'b0; instruction_in = '0; pc_in = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", stall_count_out, 0);
    rst = 1'b0;

    send(I_ADDI, 32'h100, it);
    check("addi_latency", it, 1);
    check("addi_valid", out_valid, 1);
    check("addi_imm", immediate_out, 32'hFFFFFFFC);
    check("addi_rd", reg_wr_addr_out, 2);
    check("addi_rs1", read_address1_out, 1);
    check("addi_wr_en", reg_wr_en_out, 1);
    check("addi_func", inst_function_out, 0);

    send(I_ORI, 32'h104, it);
    check("ori_imm", immediate_out, 32'h0000FFFF);
    check("ori_imm_inst", imm_inst_out, 1);

    stalls_seen = 0;
    send(I_LW3, 32'h108, it);
    check("lw_rd_en", mem_data_rd_en_out, 1);
    check("lw_wb_sel", write_back_mux_sel_out, 1);
    send(I_ADD, 32'h10C, it);
    check("hz_iters", it, HZ ? 2 : 1);
    check("hz_stall_seen", stalls_seen, HZ ? 1 : 0);
    check("hz_stall_count", stall_count_out, HZ ? 1 : 0);
    check("add_rs1", read_address1_out, 3);
    check("add_rs2", read_address2_out, 5);
    check("add_rd", reg_wr_addr_out, 4);
    check("add_pc", pc_out, 32'h10C);

    stalls_seen = 0;
    send(I_LW0, 32'h110, it);
    send(I_ADD0, 32'h114, it);
    check("r0_iters", it, 1);
    check("r0_stall_seen", stalls_seen, 0);
    check("r0_count", stall_count_out, HZ ? 1 : 0);

    send(I_SW, 32'h200, it);
    out_ready = 1'b0;
    in_valid = 1'b1; instruction_in = I_BEQZ; pc_in = 32'h204;
    repeat (3) begin
      #1;
      check("hold_in_ready", in_ready, 0);
      check("hold_opcode", opcode_out, 6'h2B);
      check("hold_wr_en", mem_data_wr_en_out, 1);
      check("hold_imm", immediate_out, 32'hFFFFFFF0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    send(I_BEQZ, 32'h204, it);
    check("release_iters", it, 1);
    check("beqz_branch", branch_inst_out, 1);
    check("beqz_imm", immediate_out, 32'hFFFF8000);
    check("beqz_rd", reg_wr_addr_out, 0);
    check("beqz_pc", pc_out, 32'h204);

    send(I_LW3, 32'h300, it);
    in_valid = 1'b1; instruction_in = I_ADD; pc_in = 32'h304; flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 1);
    check("flush_stall", stall_out, 0);
    @(posedge clk); #2;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_count", stall_count_out, HZ ? 1 : 0);
    @(posedge clk); #2;
    check("flush_dropped", out_valid, 0);

    send(I_ILL, 32'h400, it);
    check("ill_flag", illegal_inst_out, 1);
    check("ill_wr_en", reg_wr_en_out, 0);
    check("ill_valid", out_valid, 1);
    send(I_JR, 32'h404, it);
    check("jr_use_r", jump_use_r_out, 1);
    check("jr_rs1", read_address1_out, 7);
    send(I_JPC, 32'h408, it);
    check("jpc_off", pc_offset_out, 26'h3FFFFFF);
    check("jpc_jump", jump_inst_out, 1);
    send(32'h0, 32'h40C, it);
    check("nop_valid", out_valid, 1);
    check("nop_illegal", illegal_inst_out, 0);
    check("nop_wr_en", reg_wr_en_out, 0);

    for (int k = 0; k < 80; k++) begin
      idx = $urandom_range(0, 7);
      in_valid = ($urandom_range(0, 3) != 0);
      instruction_in = tbl[idx];
      pc_in = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 11) == 0);
      @(posedge clk); #2;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;

    send(I_ADDI, 32'h500, it);
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_imm", immediate_out, 0);
    check("midrst_rd", reg_wr_addr_out, 0);
    check("midrst_pc", pc_out, 0);
    check("midrst_count", stall_count_out, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_stall", stall_out, 0);
    @(posedge clk); #2;
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
